rv32i_lsu: RTL and testbench
============================

# rv32i_lsu

Load/store unit for the RV32I back end. It takes the effective address produced by the ALU for LB/LH/LW/LBU/LHU/SB/SH/SW, plus the store operand. It drives a single-outstanding req/ready data-memory port, applies byte-lane steering, sign- or zero-extends load data, and flags misaligned or timed-out accesses. It sits between the execute stage and data memory, and stalls the core through `busy`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles to wait for `mem_ready`. A value of 0 disables the timeout.

Ports. The design uses one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `mnemonic`  in  RV32I_INSTRUCTION_MNEMONIC_t  LB, LH, LW, LBU, LHU, SB, SH, SW. Any other value makes `start` be ignored.
- `addr`  in  32  effective address from the ALU.
- `store_data`  in  32  rs2 value.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  1 for stores.
- `mem_addr`  out  32  word address: `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  completion strobe from memory.
- `mem_rdata`  in  32  read word, valid when `mem_ready` is high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  32  extended load result. Valid with `done` and held until the next `done`.
- `misaligned`  out  1  pulses with `done`. The access was not issued.
- `bus_error`  out  1  pulses with `done`. The access timed out.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `start` with a valid mnemonic latches mnemonic, addr and store_data.
  - A misaligned access goes to RESP with `misaligned` set:
    - halfword ops: `addr[0]` = 1;
    - word ops: `addr[1:0]` ≠ 0.
  - Otherwise the FSM goes to ACCESS.
- ACCESS:
  - `mem_req` = 1, with `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stable throughout.
  - `mem_ready` goes to RESP. Load data is captured in the same cycle.
  - If the wait counter reaches `TIMEOUT_CYCLES`, go to RESP with `bus_error` set.
- RESP: `done` = 1 for one cycle, then IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << addr[1:0]`;
  - word: `4'b1111`.
  - Loads also drive `mem_be` for the bytes they read.
- Write data:
  - SB: `{4{sd[7:0]}}`;
  - SH: `{2{sd[15:0]}}`;
  - SW: `sd`.
- Load extraction:
  - select the byte or half at `addr[1:0]` (or `addr[1]` for halves);
  - LB and LH sign-extend;
  - LBU and LHU zero-extend;
  - LW takes the whole word.
- On error (misaligned or timeout), `load_data` holds its previous value.
- `mem_ready` outside ACCESS is ignored.
- The wait counter is 8 bits, clears on entry to ACCESS, and saturates.

## Timing
- Reset values: state IDLE; all outputs 0, including `load_data` = 0 and `mem_addr` = 0.
- Reset takes effect in any state. It drops `mem_req` the next cycle, and no `done` is produced.
- `start` at cycle 0 gives `mem_req` = 1 from cycle 1.
- If `mem_ready` is high at cycle n (n ≥ 1), `done` is high at cycle n+1 and `busy` is low at cycle n+2.
- Minimum latency from `start` to `done` is 2 cycles.
- A misaligned access gives `done` and `misaligned` at cycle 1, with no `mem_req`.
- Timeout: `bus_error` and `done` occur `TIMEOUT_CYCLES`+1 cycles after `mem_req` rises.
- `start` while `busy` is ignored. A new request is accepted in the cycle `busy` = 0.
- The transaction completes in exactly one handshake: a single-cycle `mem_ready` is sufficient.

## Structure
- Add to be_pkg:
  - `LSU_STATE_t` enum;
  - `LSU_SIZE_t` (BYTE, HALF, WORD);
  - the helper function mapping mnemonic to size, sign and write.
- Sub-module `lsu_lane_align`: combinational byte-enable, write-data replication and load-extraction logic. The FSM, counter and registers stay in `rv32i_lsu`.

## Test plan
- LW, addr `0x0000_1004`, ready at cycle 1, rdata `0xDEADBEEF`:
  - `mem_addr` = `0x1004`, `mem_be` = `4'hF`;
  - `done` at cycle 2, `load_data` = `0xDEADBEEF`.
- LB and LBU, addr `0x1003`, rdata `0x80FF_7F01`:
  - LB gives `0xFFFF_FF80`, LBU gives `0x0000_0080`;
  - `mem_be` = `4'b1000`.
- SH, addr `0x2002`, store_data `0x1234_ABCD`:
  - `mem_we` = 1, `mem_be` = `4'b1100`, `mem_wdata` = `0xABCD_ABCD`;
  - all request outputs are held stable over 3 wait cycles before `mem_ready`.
- SW, addr `0x3001`:
  - `misaligned` and `done` at cycle 1;
  - `mem_req` never asserts.
- LH with `TIMEOUT_CYCLES` = 4 and `mem_ready` never asserted:
  - `bus_error` and `done` at cycle 6;
  - `load_data` unchanged.
- `rst` asserted in ACCESS:
  - next cycle `mem_req` = 0, `busy` = 0, and no `done`;
  - a subsequent LW completes normally.

Source files
------------

// File: rtl/be_pkg.sv
// Back-end shared types: instruction mnemonics, LSU state/size encodings
// and the mnemonic-to-access decode helper.
package be_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_RESP
    } LSU_STATE_t;

    typedef enum logic [1:0] {
        LSU_BYTE,
        LSU_HALF,
        LSU_WORD
    } LSU_SIZE_t;

    typedef struct packed {
        logic      valid;
        LSU_SIZE_t size;
        logic      is_signed;
        logic      write;
    } lsu_op_t;

    function automatic lsu_op_t lsu_decode(input RV32I_INSTRUCTION_MNEMONIC_t m);
        lsu_op_t op;
        op.valid     = 1'b1;
        op.size      = LSU_WORD;
        op.is_signed = 1'b0;
        op.write     = 1'b0;
        case (m)
            LB:      begin op.size = LSU_BYTE; op.is_signed = 1'b1; end
            LH:      begin op.size = LSU_HALF; op.is_signed = 1'b1; end
            LW:      op.size = LSU_WORD;
            LBU:     op.size = LSU_BYTE;
            LHU:     op.size = LSU_HALF;
            SB:      begin op.size = LSU_BYTE; op.write = 1'b1; end
            SH:      begin op.size = LSU_HALF; op.write = 1'b1; end
            SW:      begin op.size = LSU_WORD; op.write = 1'b1; end
            default: op.valid = 1'b0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_lane_align
    import be_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Lane selection per access size
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            LSU_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
            end
            LSU_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{is_signed & sel_half[15]}}, sel_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding req/ready data port with
// misalignment detection and a saturating wait-cycle timeout.
module rv32i_lsu
    import be_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 store_data,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [3:0]                  mem_be,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_ready,
    input  logic [31:0]                 mem_rdata,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 load_data,
    output logic                        misaligned,
    output logic                        bus_error
);

    LSU_STATE_t  state;
    LSU_SIZE_t   size_q;
    logic        signed_q;
    logic        write_q;
    logic [1:0]  addr_lo_q;
    logic [7:0]  wait_cnt;

    lsu_op_t     dec;
    logic        dec_misaligned;
    logic        timed_out;
    LSU_SIZE_t   sel_size;
    logic        sel_signed;
    logic [1:0]  sel_addr_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign dec = lsu_decode(mnemonic);
    assign dec_misaligned = ((dec.size == LSU_HALF) && addr[0]) ||
                            ((dec.size == LSU_WORD) && (addr[1:0] != 2'b00));
    assign timed_out = (TIMEOUT_CYCLES != 0) && (32'(wait_cnt) == TIMEOUT_CYCLES);

    // One lane aligner serves both phases: live inputs in IDLE to form the
    // request, latched access attributes afterwards to extract load data.
    assign sel_size    = (state == LSU_IDLE) ? dec.size      : size_q;
    assign sel_signed  = (state == LSU_IDLE) ? dec.is_signed : signed_q;
    assign sel_addr_lo = (state == LSU_IDLE) ? addr[1:0]     : addr_lo_q;

    lsu_lane_align u_align (
        .size       (sel_size),
        .is_signed  (sel_signed),
        .addr_lo    (sel_addr_lo),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // Control FSM with registered memory-port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LSU_IDLE;
            size_q     <= LSU_BYTE;
            signed_q   <= 1'b0;
            write_q    <= 1'b0;
            addr_lo_q  <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_data  <= '0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (start && dec.valid) begin
                        size_q    <= dec.size;
                        signed_q  <= dec.is_signed;
                        write_q   <= dec.write;
                        addr_lo_q <= addr[1:0];
                        busy      <= 1'b1;
                        if (dec_misaligned) begin
                            state      <= LSU_RESP;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state     <= LSU_ACCESS;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= dec.write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= lane_be;
                            mem_wdata <= lane_wdata;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (mem_ready) begin
                        state   <= LSU_RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!write_q) begin
                            load_data <= lane_load;
                        end
                    end else if (timed_out) begin
                        state     <= LSU_RESP;
                        mem_req   <= 1'b0;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                LSU_RESP: begin
                    state <= LSU_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= LSU_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed test-plan cases plus random
// transactions, checked every cycle against a transaction-level model.
module tb_rv32i_lsu;
    import be_pkg::*;

    localparam int unsigned T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic = ADD;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0] mem_be;
    logic busy, done, misaligned, bus_error;
    logic [31:0] load_data;

    rv32i_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .start(start), .mnemonic(mnemonic),
        .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .load_data(load_data),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected outputs for the current cycle, written by the driver
    bit          chk_en = 1'b0;
    bit          exp_busy, exp_req, exp_done, exp_mis, exp_berr;
    logic [31:0] exp_load = '0;
    bit          exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    RV32I_INSTRUCTION_MNEMONIC_t pool [10] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, JAL};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: access width in bytes (0 = not a memory op), signedness, direction
    function automatic void mdl_op(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                   output int n, output bit sgn, output bit wr);
        n = 0; sgn = 0; wr = 0;
        case (m)
            LB:  begin n = 1; sgn = 1; end
            LH:  begin n = 2; sgn = 1; end
            LW:  n = 4;
            LBU: n = 1;
            LHU: n = 2;
            SB:  begin n = 1; wr = 1; end
            SH:  begin n = 2; wr = 1; end
            SW:  begin n = 4; wr = 1; end
            default: n = 0;
        endcase
    endfunction

    function automatic logic [3:0] mdl_be(input int n, input logic [31:0] a);
        int m;
        m = ((1 << n) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] mdl_wdata(input int n, input logic [31:0] sd);
        logic [31:0] v, mask, r;
        if (n == 4) return sd;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = sd & mask;
        r = '0;
        for (int i = 0; i < 4 / n; i++) r = r | (v << (8 * n * i));
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input int n, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        if (n == 4) return rd;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * (a % 4))) & mask;
        if (sgn && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_exp(input bit b, input bit r, input bit d, input bit m, input bit e);
        exp_busy = b; exp_req = r; exp_done = d; exp_mis = m; exp_berr = e;
    endtask

    // Advance one cycle and fill inputs with noise that the DUT must ignore
    task automatic next_cycle(input bit noise);
        @(posedge clk);
        #1;
        start      = noise && ($urandom_range(0, 3) == 0);
        mnemonic   = pool[$urandom_range(0, 9)];
        addr       = $urandom;
        store_data = $urandom;
        mem_ready  = 1'b0;
        mem_rdata  = $urandom;
    endtask

    // One request; delay = wait cycles before mem_ready, or -1 for none
    task automatic txn(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [31:0] a,
                       input logic [31:0] sd, input int delay, input logic [31:0] rd);
        int n; bit sgn, wr;
        next_cycle(0);
        set_exp(0, 0, 0, 0, 0);
        start = 1; mnemonic = mn; addr = a; store_data = sd;
        mem_ready = 1'($urandom_range(0, 1));
        mdl_op(mn, n, sgn, wr);
        if (n == 0) return;
        if ((a % n) != 0) begin
            next_cycle(1);
            set_exp(1, 0, 1, 1, 0);
            return;
        end
        exp_we = wr; exp_addr = a & 32'hFFFF_FFFC;
        exp_be = mdl_be(n, a); exp_wdata = mdl_wdata(n, sd);
        for (int k = 0; k < 300; k++) begin
            next_cycle(1);
            set_exp(1, 1, 0, 0, 0);
            if (k == delay) begin
                mem_ready = 1; mem_rdata = rd;
                break;
            end
            if (delay < 0 && k == int'(T)) break;
        end
        next_cycle(1);
        mem_ready = 1'($urandom_range(0, 1));
        set_exp(1, 0, 1, 0, delay < 0);
        if (delay >= 0 && !wr) exp_load = mdl_load(n, sgn, a, rd);
    endtask

    // Per-cycle comparison of DUT outputs against the model expectations
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", 32'(busy), 32'(exp_busy));
                check("mem_req", 32'(mem_req), 32'(exp_req));
                check("done", 32'(done), 32'(exp_done));
                check("misaligned", 32'(misaligned), 32'(exp_mis));
                check("bus_error", 32'(bus_error), 32'(exp_berr));
                check("load_data", load_data, exp_load);
                if (exp_req) begin
                    check("mem_we", 32'(mem_we), 32'(exp_we));
                    check("mem_addr", mem_addr, exp_addr);
                    check("mem_be", 32'(mem_be), 32'(exp_be));
                    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n; bit sgn, wr; int dly;
        repeat (3) next_cycle(0);
        rst = 0;
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_load", load_data, 0);
        check("rst_flags", {30'd0, misaligned, bus_error}, 0);
        set_exp(0, 0, 0, 0, 0);
        exp_load = '0;
        chk_en = 1;

        // Model pins from hand-computed values
        check("mdl_be_lb", 32'(mdl_be(1, 32'h1003)), 32'h8);
        check("mdl_be_sh", 32'(mdl_be(2, 32'h2002)), 32'hC);
        check("mdl_wd_sh", mdl_wdata(2, 32'h1234_ABCD), 32'hABCD_ABCD);
        check("mdl_ld_lb", mdl_load(1, 1, 32'h1003, 32'h80FF_7F01), 32'hFFFF_FF80);

        txn(LW, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF);
        check("lw_data", load_data, 32'hDEAD_BEEF);
        txn(LB, 32'h0000_1003, 32'h0, 0, 32'h80FF_7F01);
        check("lb_data", load_data, 32'hFFFF_FF80);
        txn(LBU, 32'h0000_1003, 32'h0, 1, 32'h80FF_7F01);
        check("lbu_data", load_data, 32'h0000_0080);
        txn(SH, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0);
        check("sh_keeps_load", load_data, 32'h0000_0080);
        txn(SW, 32'h0000_3001, 32'h5555_AAAA, 0, 32'h0);
        txn(LH, 32'h0000_4000, 32'h0, -1, 32'h0);
        check("timeout_keeps_load", load_data, 32'h0000_0080);
        txn(ADD, 32'h0000_0000, 32'h0, 0, 32'h0);

        // Reset while in ACCESS
        next_cycle(0);
        set_exp(0, 0, 0, 0, 0);
        start = 1; mnemonic = LW; addr = 32'h0000_5008;
        next_cycle(1);
        set_exp(1, 1, 0, 0, 0);
        exp_we = 0; exp_addr = 32'h0000_5008; exp_be = 4'hF;
        rst = 1;
        next_cycle(0);
        rst = 0;
        set_exp(0, 0, 0, 0, 0);
        exp_load = '0;
        txn(LW, 32'h0000_6000, 32'h0, 2, 32'hCAFE_F00D);
        check("lw_after_rst", load_data, 32'hCAFE_F00D);

        for (int i = 0; i < 150; i++) begin
            RV32I_INSTRUCTION_MNEMONIC_t mn;
            mn = pool[$urandom_range(0, 9)];
            mdl_op(mn, n, sgn, wr);
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, T - 1));
            txn(mn, $urandom, $urandom, dly, $urandom);
        end

        next_cycle(0);
        set_exp(0, 0, 0, 0, 0);
        next_cycle(0);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
